// File: rtl/keypoint_reader.sv
// keypoint_reader: walks keypoint SRAM 1 then SRAM 2 after a detection pass and
// streams the unpacked {row, col} entries downstream over valid/ready. A small
// skid FIFO covers the one-cycle SRAM read latency under back-pressure.
// Optional build macro: KEYPOINT_BORDER_FILTER_EN drops entries closer than
// BORDER pixels to the image edge and counts them in dropped_cnt.
module keypoint_reader #(
   parameter int unsigned ADDR_W     = 11,
   parameter int unsigned ROW_W      = 9,
   parameter int unsigned COL_W      = 10,
   parameter int unsigned IMG_ROWS   = 480,
   parameter int unsigned IMG_COLS   = 640,
   parameter int unsigned BORDER     = 8,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [ADDR_W:0]        kp1_count,
   input  logic [ADDR_W:0]        kp2_count,
   output logic                   busy,
   output logic                   done,
   output logic                   keypoint_1_re,
   output logic [ADDR_W-1:0]      keypoint_1_addr,
   input  logic [ROW_W+COL_W-1:0] keypoint_1_dout,
   output logic                   keypoint_2_re,
   output logic [ADDR_W-1:0]      keypoint_2_addr,
   input  logic [ROW_W+COL_W-1:0] keypoint_2_dout,
   output logic                   kp_valid,
   input  logic                   kp_ready,
   output logic [ROW_W-1:0]       kp_row,
   output logic [COL_W-1:0]       kp_col,
   output logic                   kp_layer,
   output logic [11:0]            dropped_cnt
);

   localparam int unsigned CNT_W = ADDR_W + 1;
   localparam int unsigned DIN_W = ROW_W + COL_W;
   localparam int unsigned ENT_W = DIN_W + 1;
   localparam int unsigned PTR_W = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned OCC_W = $clog2(FIFO_DEPTH + 1) + 1;

   // Reject configurations the credit scheme or border window cannot support
   if (FIFO_DEPTH < 2 || 2 * BORDER >= IMG_ROWS || 2 * BORDER >= IMG_COLS) begin : g_cfg_check
      $error("keypoint_reader: unsupported FIFO_DEPTH/BORDER/image configuration");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH1,
      S_FETCH2,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t             state, next_state;
   logic [CNT_W-1:0]   cnt1_q, cnt2_q;
   logic [ADDR_W-1:0]  rd_addr;
   logic               inflight, inflight_layer;
   logic [ENT_W-1:0]   fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr, rd_ptr;
   logic [OCC_W-1:0]   occ;
   logic               issue, pop, push, keep, credit_ok, last1, last2;
   logic [DIN_W-1:0]   cap_word;
   logic [ROW_W-1:0]   cap_row;
   logic [COL_W-1:0]   cap_col;
   logic [ENT_W-1:0]   head;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Credit check: a read may issue only if its data is guaranteed a FIFO slot
   assign pop       = (occ != '0) && kp_ready;
   assign credit_ok = (occ + OCC_W'(inflight) - OCC_W'(pop)) < OCC_W'(FIFO_DEPTH);
   assign last1     = ({1'b0, rd_addr} == cnt1_q - CNT_W'(1));
   assign last2     = ({1'b0, rd_addr} == cnt2_q - CNT_W'(1));

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= next_state;
   end

   // Next-state and read-issue decode
   always_comb begin
      next_state = state;
      issue      = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               if (kp1_count != '0)      next_state = S_FETCH1;
               else if (kp2_count != '0) next_state = S_FETCH2;
               else                      next_state = S_DONE;
            end
         end
         S_FETCH1: begin
            issue = credit_ok;
            if (issue && last1) next_state = (cnt2_q != '0) ? S_FETCH2 : S_DRAIN;
         end
         S_FETCH2: begin
            issue = credit_ok;
            if (issue && last2) next_state = S_DRAIN;
         end
         S_DRAIN: begin
            if (!inflight && occ == '0) next_state = S_DONE;
         end
         S_DONE:  next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   assign keypoint_1_re   = issue && (state == S_FETCH1);
   assign keypoint_2_re   = issue && (state == S_FETCH2);
   assign keypoint_1_addr = rd_addr;
   assign keypoint_2_addr = rd_addr;

   // Pass control: latched counts, read address, in-flight tag, status flags
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt1_q         <= '0;
         cnt2_q         <= '0;
         rd_addr        <= '0;
         inflight       <= 1'b0;
         inflight_layer <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
      end else begin
         busy           <= next_state inside {S_FETCH1, S_FETCH2, S_DRAIN};
         done           <= (next_state == S_DONE);
         inflight       <= issue;
         inflight_layer <= (state == S_FETCH2);
         if (state == S_IDLE && start) begin
            cnt1_q <= kp1_count;
            cnt2_q <= kp2_count;
         end
         if (next_state != state) rd_addr <= '0;
         else if (issue)          rd_addr <= rd_addr + ADDR_W'(1);
      end
   end

   assign cap_word = inflight_layer ? keypoint_2_dout : keypoint_1_dout;
   assign cap_row  = cap_word[DIN_W-1:COL_W];
   assign cap_col  = cap_word[COL_W-1:0];
   assign push     = inflight && keep;

`ifdef KEYPOINT_BORDER_FILTER_EN
   localparam logic [ROW_W-1:0] ROW_LO = ROW_W'(BORDER);
   localparam logic [ROW_W-1:0] ROW_HI = ROW_W'(IMG_ROWS - BORDER);
   localparam logic [COL_W-1:0] COL_LO = COL_W'(BORDER);
   localparam logic [COL_W-1:0] COL_HI = COL_W'(IMG_COLS - BORDER);

   assign keep = (cap_row >= ROW_LO) && (cap_row < ROW_HI) &&
                 (cap_col >= COL_LO) && (cap_col < COL_HI);

   // Saturating count of border discards, cleared when a pass starts
   always_ff @(posedge clk) begin
      if (rst)                             dropped_cnt <= '0;
      else if (state == S_IDLE && start)   dropped_cnt <= '0;
      else if (inflight && !keep && dropped_cnt != 12'hFFF)
                                           dropped_cnt <= dropped_cnt + 12'd1;
   end
`else
   assign keep        = 1'b1;
   assign dropped_cnt = '0;
`endif

   // Skid FIFO holding layer-tagged entries until downstream accepts them
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
      end else begin
         if (push) begin
            fifo_mem[wr_ptr] <= {inflight_layer, cap_row, cap_col};
            wr_ptr           <= ptr_inc(wr_ptr);
         end
         if (pop) rd_ptr <= ptr_inc(rd_ptr);
         occ <= occ + OCC_W'(push) - OCC_W'(pop);
      end
   end

   assign head     = fifo_mem[rd_ptr];
   assign kp_valid = (occ != '0);
   assign kp_layer = head[DIN_W];
   assign kp_row   = head[DIN_W-1:COL_W];
   assign kp_col   = head[COL_W-1:0];

endmodule

// File: tb/tb_keypoint_reader.sv
// Directed bench for keypoint_reader: SRAM models with one-cycle read latency,
// a pass runner that records beats and protocol observations, and one task per
// scenario doing its own comparisons against hand-derived values.
module tb_keypoint_reader;

   logic        clk = 1'b0;
   logic        rst, start, kp_ready;
   logic [11:0] kp1_count, kp2_count;
   logic        busy, done, keypoint_1_re, keypoint_2_re;
   logic [10:0] keypoint_1_addr, keypoint_2_addr;
   logic [18:0] keypoint_1_dout, keypoint_2_dout;
   logic        kp_valid, kp_layer;
   logic [8:0]  kp_row;
   logic [9:0]  kp_col;
   logic [11:0] dropped_cnt;

   logic [18:0] mem1 [2048];
   logic [18:0] mem2 [2048];

   int errors = 0;
   int checks = 0;

   // Observations gathered by run_pass
   logic [19:0] beats[$];
   int          beat_cyc[$];
   int          done_cyc, done_cnt, busy_cnt, re_cnt;
   int          stable_err, credit_err, addr_err, last_addr1;

   always #5 clk = ~clk;

   keypoint_reader dut (
      .clk             (clk),
      .rst             (rst),
      .start           (start),
      .kp1_count       (kp1_count),
      .kp2_count       (kp2_count),
      .busy            (busy),
      .done            (done),
      .keypoint_1_re   (keypoint_1_re),
      .keypoint_1_addr (keypoint_1_addr),
      .keypoint_1_dout (keypoint_1_dout),
      .keypoint_2_re   (keypoint_2_re),
      .keypoint_2_addr (keypoint_2_addr),
      .keypoint_2_dout (keypoint_2_dout),
      .kp_valid        (kp_valid),
      .kp_ready        (kp_ready),
      .kp_row          (kp_row),
      .kp_col          (kp_col),
      .kp_layer        (kp_layer),
      .dropped_cnt     (dropped_cnt)
   );

   // Synchronous-read SRAM models
   always @(posedge clk) begin
      if (keypoint_1_re) keypoint_1_dout <= mem1[keypoint_1_addr];
      if (keypoint_2_re) keypoint_2_dout <= mem2[keypoint_2_addr];
   end

   task automatic fill_default();
      for (int i = 0; i < 2048; i++) begin
         mem1[i] = {9'(8 + i % 400), 10'(8 + (i * 3) % 600)};
         mem2[i] = {9'(20 + (i * 7) % 400), 10'(100 + i % 500)};
      end
   endtask

   // Runs one pass from a start pulse; ready_mode 0 = always ready, 1 = 1,0,0,1 pattern
   task automatic run_pass(input int c1, input int c2, input int ready_mode, input int max_cyc);
      int          issued, popped, exp_a1, exp_a2;
      bit          prev_valid, prev_ready, p;
      logic [19:0] prev_pl, pl;
      beats.delete();
      beat_cyc.delete();
      done_cyc = -1; done_cnt = 0; busy_cnt = 0; re_cnt = 0;
      stable_err = 0; credit_err = 0; addr_err = 0; last_addr1 = -1;
      issued = 0; popped = 0; exp_a1 = 0; exp_a2 = 0;
      prev_valid = 1'b0; prev_ready = 1'b1; prev_pl = '0;
      for (int cyc = 0; cyc <= max_cyc; cyc++) begin
         @(negedge clk);
         start     = (cyc == 0);
         kp1_count = 12'(c1);
         kp2_count = 12'(c2);
         kp_ready  = (ready_mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
         #1;
         pl = {kp_layer, kp_row, kp_col};
         p  = kp_valid && kp_ready;
         if (busy) busy_cnt++;
         if (done) begin done_cnt++; done_cyc = cyc; end
         if (prev_valid && !prev_ready && (!kp_valid || pl != prev_pl)) stable_err++;
         if (keypoint_1_re && keypoint_2_re) addr_err++;
         if (keypoint_1_re || keypoint_2_re) begin
            re_cnt++;
            if (issued - popped - int'(p) >= 2) credit_err++;
            issued++;
         end
         if (keypoint_1_re) begin
            if (int'(keypoint_1_addr) != exp_a1) addr_err++;
            exp_a1++;
            last_addr1 = int'(keypoint_1_addr);
         end
         if (keypoint_2_re) begin
            if (int'(keypoint_2_addr) != exp_a2) addr_err++;
            exp_a2++;
         end
         if (p) begin
            beats.push_back(pl);
            beat_cyc.push_back(cyc);
            popped++;
         end
         prev_valid = kp_valid;
         prev_ready = kp_ready;
         prev_pl    = pl;
         if (done_cnt > 0 && cyc >= done_cyc + 2) break;
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; kp_ready = 1'b1; kp1_count = '0; kp2_count = '0;
      repeat (3) @(negedge clk);
      #1;
      checks++; if ({busy, done, kp_valid} !== 3'b000) begin errors++;
         $display("FAIL reset_flags: got %b required 000", {busy, done, kp_valid}); end
      checks++; if ({keypoint_1_re, keypoint_2_re} !== 2'b00) begin errors++;
         $display("FAIL reset_re: got %b required 00", {keypoint_1_re, keypoint_2_re}); end
      checks++; if ({keypoint_1_addr, keypoint_2_addr} !== 22'd0) begin errors++;
         $display("FAIL reset_addr: got %h/%h required 0", keypoint_1_addr, keypoint_2_addr); end
      checks++; if ({kp_layer, kp_row, kp_col} !== 20'd0) begin errors++;
         $display("FAIL reset_payload: got %h required 0", {kp_layer, kp_row, kp_col}); end
      checks++; if (dropped_cnt !== 12'd0) begin errors++;
         $display("FAIL reset_dropped: got %0d required 0", dropped_cnt); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_basic();
      logic [19:0] exp;
      fill_default();
      run_pass(3, 2, 0, 40);
      checks++; if (beats.size() !== 5) begin errors++;
         $display("FAIL basic_count: got %0d beats required 5", beats.size()); end
      for (int j = 0; j < 5 && j < beats.size(); j++) begin
         exp = (j < 3) ? {1'b0, mem1[j]} : {1'b1, mem2[j-3]};
         checks++; if (beats[j] !== exp) begin errors++;
            $display("FAIL basic_beat%0d: got %h required %h", j, beats[j], exp); end
         checks++; if (beat_cyc[j] !== 3 + j) begin errors++;
            $display("FAIL basic_cycle%0d: got %0d required %0d", j, beat_cyc[j], 3 + j); end
      end
      checks++; if (done_cyc !== 9 || done_cnt !== 1) begin errors++;
         $display("FAIL basic_done: got cycle %0d count %0d required cycle 9 count 1", done_cyc, done_cnt); end
      checks++; if (busy_cnt !== 8) begin errors++;
         $display("FAIL basic_busy: got %0d busy cycles required 8", busy_cnt); end
   endtask

   task automatic test_zero();
      run_pass(0, 0, 0, 20);
      checks++; if (done_cyc !== 1 || done_cnt !== 1) begin errors++;
         $display("FAIL zero_done: got cycle %0d count %0d required cycle 1 count 1", done_cyc, done_cnt); end
      checks++; if (busy_cnt !== 0) begin errors++;
         $display("FAIL zero_busy: got %0d required 0", busy_cnt); end
      checks++; if (re_cnt !== 0 || beats.size() !== 0) begin errors++;
         $display("FAIL zero_activity: got re %0d beats %0d required 0 0", re_cnt, beats.size()); end
   endtask

   task automatic test_stall();
      fill_default();
      run_pass(4, 0, 1, 80);
      checks++; if (beats.size() !== 4) begin errors++;
         $display("FAIL stall_count: got %0d beats required 4", beats.size()); end
      for (int j = 0; j < 4 && j < beats.size(); j++) begin
         checks++; if (beats[j] !== {1'b0, mem1[j]}) begin errors++;
            $display("FAIL stall_beat%0d: got %h required %h", j, beats[j], {1'b0, mem1[j]}); end
      end
      checks++; if (stable_err !== 0) begin errors++;
         $display("FAIL stall_stable: got %0d changes required 0", stable_err); end
      checks++; if (credit_err !== 0) begin errors++;
         $display("FAIL stall_credit: got %0d overissues required 0", credit_err); end
      checks++; if (done_cnt !== 1) begin errors++;
         $display("FAIL stall_done: got %0d pulses required 1", done_cnt); end
   endtask

   task automatic test_border();
      fill_default();
      mem1[0] = {9'd3,   10'd100};
      mem1[1] = {9'd100, 10'd100};
      mem1[2] = {9'd475, 10'd5};
      mem1[3] = {9'd200, 10'd635};
      run_pass(4, 0, 0, 40);
`ifdef KEYPOINT_BORDER_FILTER_EN
      checks++; if (beats.size() !== 1) begin errors++;
         $display("FAIL border_count: got %0d beats required 1", beats.size()); end
      if (beats.size() > 0) begin
         checks++; if (beats[0] !== {1'b0, 9'd100, 10'd100}) begin errors++;
            $display("FAIL border_beat: got %h required %h", beats[0], {1'b0, 9'd100, 10'd100}); end
      end
      checks++; if (dropped_cnt !== 12'd3) begin errors++;
         $display("FAIL border_dropped: got %0d required 3", dropped_cnt); end
`else
      checks++; if (beats.size() !== 4) begin errors++;
         $display("FAIL border_count: got %0d beats required 4", beats.size()); end
      checks++; if (dropped_cnt !== 12'd0) begin errors++;
         $display("FAIL border_dropped: got %0d required 0", dropped_cnt); end
`endif
      checks++; if (done_cnt !== 1) begin errors++;
         $display("FAIL border_done: got %0d pulses required 1", done_cnt); end
      fill_default();
   endtask

   task automatic test_reset_mid();
      bit hit = 1'b0;
      int late_done = 0;
      fill_default();
      for (int cyc = 0; cyc < 30 && !hit; cyc++) begin
         @(negedge clk);
         start = (cyc == 0); kp1_count = 12'd3; kp2_count = 12'd5; kp_ready = 1'b1;
         #1;
         hit = keypoint_2_re && (keypoint_2_addr == 11'd2);
      end
      checks++; if (!hit) begin errors++;
         $display("FAIL midrst_reach: got no FETCH2 address 2 required it within 30 cycles"); end
      @(negedge clk);
      start = 1'b0; rst = 1'b1;
      @(negedge clk);
      #1;
      checks++; if ({busy, done, kp_valid, keypoint_1_re, keypoint_2_re} !== 5'b0) begin errors++;
         $display("FAIL midrst_flags: got %b required 00000",
                  {busy, done, kp_valid, keypoint_1_re, keypoint_2_re}); end
      checks++; if ({keypoint_1_addr, keypoint_2_addr, kp_layer, kp_row, kp_col} !== 42'd0) begin errors++;
         $display("FAIL midrst_data: got %h required 0",
                  {keypoint_1_addr, keypoint_2_addr, kp_layer, kp_row, kp_col}); end
      rst = 1'b0;
      repeat (4) begin
         @(negedge clk); #1;
         if (done || busy || kp_valid) late_done++;
      end
      checks++; if (late_done !== 0) begin errors++;
         $display("FAIL midrst_quiet: got %0d active cycles required 0", late_done); end
      run_pass(2, 1, 0, 40);
      checks++; if (beats.size() !== 3) begin errors++;
         $display("FAIL midrst_count: got %0d beats required 3", beats.size()); end
      if (beats.size() == 3) begin
         checks++; if ({beats[0], beats[1], beats[2]} !== {1'b0, mem1[0], 1'b0, mem1[1], 1'b1, mem2[0]}) begin errors++;
            $display("FAIL midrst_beats: got %h %h %h required %h %h %h", beats[0], beats[1], beats[2],
                     {1'b0, mem1[0]}, {1'b0, mem1[1]}, {1'b1, mem2[0]}); end
      end
      checks++; if (addr_err !== 0 || done_cnt !== 1) begin errors++;
         $display("FAIL midrst_pass: got addr errors %0d done %0d required 0 1", addr_err, done_cnt); end
   endtask

   task automatic test_full();
      int bad = 0;
      logic [19:0] exp;
      fill_default();
      run_pass(2048, 2048, 0, 4300);
      checks++; if (beats.size() !== 4096) begin errors++;
         $display("FAIL full_count: got %0d beats required 4096", beats.size()); end
      for (int j = 0; j < beats.size(); j++) begin
         exp = (j < 2048) ? {1'b0, mem1[j]} : {1'b1, mem2[j-2048]};
         if (beats[j] !== exp) bad++;
      end
      checks++; if (bad !== 0) begin errors++;
         $display("FAIL full_data: got %0d wrong beats required 0", bad); end
      checks++; if (last_addr1 !== 2047) begin errors++;
         $display("FAIL full_last_addr1: got %0d required 2047", last_addr1); end
      checks++; if (addr_err !== 0 || re_cnt !== 4096) begin errors++;
         $display("FAIL full_addr: got errors %0d reads %0d required 0 4096", addr_err, re_cnt); end
      if (beat_cyc.size() == 4096) begin
         checks++; if (beat_cyc[4095] !== 4098) begin errors++;
            $display("FAIL full_throughput: got last beat cycle %0d required 4098", beat_cyc[4095]); end
      end
      checks++; if (done_cnt !== 1) begin errors++;
         $display("FAIL full_done: got %0d pulses required 1", done_cnt); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero();
      test_stall();
      test_border();
      test_reset_mid();
      test_full();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
